// File: rtl/fpu_arb.sv
// fpu_arb: round-robin arbiter that shares one multi-cycle float unit among
// N requesters. The winner's operands are latched, the unit is cleared for
// one cycle, started for one cycle, then the FSM waits for fu_done under a
// watchdog and returns the result with a one-cycle one-hot ack.
//
// Handshake: req is a level request; a requester holds req until its ack
// pulse. The ack cycle is the only cycle in which res/err are meaningful.
// On the float-unit side, fu_start is a one-cycle pulse and fu_done is a
// level that is only looked at while waiting for the result.
module fpu_arb #(
  parameter int S   = 32,
  parameter int N   = 4,
  parameter int TMO = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*S-1:0]         a,
  input  logic [N*S-1:0]         b,
  output logic [N-1:0]           ack,
  output logic [S-1:0]           res,
  output logic                   err,
  output logic                   busy,
  output logic                   fu_rst_n,
  output logic                   fu_start,
  output logic [S-1:0]           fu_a,
  output logic [S-1:0]           fu_b,
  input  logic [S-1:0]           fu_o,
  input  logic                   fu_done,
  output logic [2:0]             state_dbg,
  output logic [$clog2(N)-1:0]   ptr_dbg
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TMO);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    DELIVER = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_q, win_d;
  logic [S-1:0]  fu_a_q, fu_a_d;
  logic [S-1:0]  fu_b_q, fu_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [S-1:0]  res_q, res_d;
  logic          err_q, err_d;

  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   rr_sum;

  // Round-robin search: first requester at or above ptr, wrapping modulo N.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_sum   = '0;
    for (int j = 0; j < N; j++) begin
      rr_sum = {1'b0, ptr_q} + (IW+1)'(j);
      if (rr_sum >= (IW+1)'(N)) rr_sum = rr_sum - (IW+1)'(N);
      if (!pick_vld && req[rr_sum[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = rr_sum[IW-1:0];
      end
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      fu_a_q  <= '0;
      fu_b_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      fu_a_q  <= fu_a_d;
      fu_b_q  <= fu_b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: grant, clear, start, wait with watchdog, deliver.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    fu_a_d  = fu_a_q;
    fu_b_d  = fu_b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          fu_a_d  = a[int'(pick_idx)*S +: S];
          fu_b_d  = b[int'(pick_idx)*S +: S];
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fu_done) begin
          res_d   = fu_o;
          err_d   = 1'b0;
          state_d = DELIVER;
        end else if (cnt_q == CW'(TMO-1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = DELIVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DELIVER: begin
        ptr_d   = (win_q == IW'(N-1)) ? '0 : win_q + IW'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    ack = '0;
    if (state_q == DELIVER) ack[win_q] = 1'b1;
    res       = (state_q == DELIVER) ? res_q : '0;
    err       = (state_q == DELIVER) ? err_q : 1'b0;
    busy      = (state_q != IDLE);
    fu_rst_n  = !(rst || (state_q == CLEAR));
    fu_start  = (state_q == ISSUE);
    fu_a      = fu_a_q;
    fu_b      = fu_b_q;
    state_dbg = state_q;
    ptr_dbg   = ptr_q;
  end

endmodule

// File: tb/tb_fpu_arb.sv
// tb_fpu_arb: directed test of fpu_arb against a behavioural float unit
// with a fixed 3-cycle latency. Expected responses are queued by the driver
// and checked by an independent monitor whenever ack is seen.
module tb_fpu_arb;

  localparam int S   = 32;
  localparam int N   = 4;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [N-1:0]   req;
  logic [N*S-1:0] a_v, b_v;
  logic [N-1:0]   ack;
  logic [S-1:0]   res;
  logic           err, busy, fu_rst_n, fu_start;
  logic [S-1:0]   fu_a, fu_b, fu_o;
  logic           fu_done;
  logic [2:0]     state_dbg;
  logic [1:0]     ptr_dbg;

  fpu_arb #(.S(S), .N(N), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a_v), .b(b_v),
    .ack(ack), .res(res), .err(err), .busy(busy),
    .fu_rst_n(fu_rst_n), .fu_start(fu_start), .fu_a(fu_a), .fu_b(fu_b),
    .fu_o(fu_o), .fu_done(fu_done), .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
  );

  // ---------------- float unit model ----------------
  function automatic logic [31:0] model_f(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h3F80_0000 && y == 32'h4000_0000) return 32'h4040_0000;
    return x ^ y;
  endfunction

  logic        unit_run, unit_done, unit_en, stale_arm, stale_clr;
  logic [1:0]  unit_cnt;
  logic [31:0] model_o;

  always @(posedge clk) begin
    if (!fu_rst_n) begin
      unit_run  <= 1'b0;
      unit_cnt  <= 2'd0;
      unit_done <= 1'b0;
      model_o   <= 32'h0;
    end else if (fu_start) begin
      unit_run  <= 1'b1;
      unit_cnt  <= 2'd0;
      unit_done <= 1'b0;
    end else if (unit_run && !unit_done) begin
      unit_cnt <= unit_cnt + 2'd1;
      if (unit_cnt == 2'd2) begin
        unit_done <= 1'b1;
        model_o   <= model_f(fu_a, fu_b);
      end
    end
  end

  // Stale completion: done held high with a bogus value until the unit starts.
  always @(posedge clk) begin
    if (!stale_arm) stale_clr <= 1'b0;
    else if (fu_start) stale_clr <= 1'b1;
  end

  assign fu_done = (unit_done & unit_en) | (stale_arm & ~stale_clr);
  assign fu_o    = (stale_arm & ~stale_clr) ? 32'hDEAD_BEEF : model_o;

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  int          ack_cnt = 0;
  int          req_cyc = 0;
  logic [S-1:0] exp_q[$];
  int          exp_idx_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];
  int          exp_wt_q[$];
  int          ack_cyc_q[$];
  int          n_clr = 0, n_start = 0, n_wait = 0;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int idx, input logic [31:0] r, input logic e,
                          input int lat, input int wt);
    exp_idx_q.push_back(idx);
    exp_q.push_back(r);
    exp_err_q.push_back(e);
    exp_lat_q.push_back(lat);
    exp_wt_q.push_back(wt);
  endtask

  // Monitor: pops one expectation per ack and checks per-operation handshakes.
  always @(negedge clk) begin
    if (ack != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {28'h0, ack}, 32'h0);
      end else begin
        int          idx, lat, wt;
        logic [31:0] r;
        logic        e;
        idx = exp_idx_q.pop_front();
        r   = exp_q.pop_front();
        e   = exp_err_q.pop_front();
        lat = exp_lat_q.pop_front();
        wt  = exp_wt_q.pop_front();
        chk("ack_onehot", {28'h0, ack}, 32'h1 << idx);
        chk("res", res, r);
        chk("err", {31'h0, err}, {31'h0, e});
        chk("clear_pulses", n_clr, 1);
        chk("start_pulses", n_start, 1);
        if (lat > 0) chk("latency", cyc - req_cyc, lat);
        if (wt > 0) chk("wait_cycles", n_wait, wt);
      end
      ack_cnt++;
      ack_cyc_q.push_back(cyc);
      n_clr = 0;
      n_start = 0;
      n_wait = 0;
    end else if (rst) begin
      n_clr = 0;
      n_start = 0;
      n_wait = 0;
    end else begin
      if (!fu_rst_n) n_clr++;
      if (fu_start) n_start++;
      if (state_dbg == 3'd3) n_wait++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("acks_seen", ack_cnt, target);
  endtask

  task automatic run_op(input logic [N-1:0] mask, input int idx, input logic [31:0] r,
                        input logic e, input int lat, input int wt);
    int target;
    @(negedge clk);
    #1;
    target = ack_cnt + 1;
    push_exp(idx, r, e, lat, wt);
    req_cyc = cyc;
    req = mask;
    wait_acks(target, 40);
    req = '0;
  endtask

  task automatic load_operands();
    for (int i = 0; i < N; i++) begin
      a_v[i*S +: S] = op_a[i];
      b_v[i*S +: S] = op_b[i];
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int target;
    op_a[0] = 32'h3F80_0000; op_b[0] = 32'h4000_0000;
    op_a[1] = 32'h1234_5678; op_b[1] = 32'h0F0F_0F0F;
    op_a[2] = 32'hA5A5_A5A5; op_b[2] = 32'h0000_FFFF;
    op_a[3] = 32'hCAFE_F00D; op_b[3] = 32'h0101_0101;
    req = '0;
    unit_en = 1'b1;
    stale_arm = 1'b0;
    load_operands();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_fu_rst_n", {31'h0, fu_rst_n}, 32'h0);
    chk("rst_ack", {28'h0, ack}, 32'h0);
    chk("rst_res", res, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_fu_start", {31'h0, fu_start}, 32'h0);
    chk("rst_fu_a", fu_a, 32'h0);
    chk("rst_fu_b", fu_b, 32'h0);
    chk("rst_state", {29'h0, state_dbg}, 32'h0);
    chk("rst_ptr", {30'h0, ptr_dbg}, 32'h0);
    #1 rst = 1'b0;

    // Single request; operands changed after the grant must not matter
    @(negedge clk);
    #1;
    target = ack_cnt + 1;
    push_exp(0, 32'h4040_0000, 1'b0, 7, 0);
    req_cyc = cyc;
    req = 4'b0001;
    repeat (2) @(negedge clk);
    #1 a_v[31:0] = 32'hFFFF_FFFF;
    wait_acks(target, 40);
    req = '0;
    load_operands();
    @(negedge clk);
    chk("idle_after_deliver", {31'h0, busy}, 32'h0);
    chk("ptr_after_single", {30'h0, ptr_dbg}, 32'h1);

    // Reset again: pointer and operand registers return to zero
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst2_ptr", {30'h0, ptr_dbg}, 32'h0);
    chk("rst2_fu_a", fu_a, 32'h0);
    chk("rst2_fu_rst_n", {31'h0, fu_rst_n}, 32'h0);
    #1 rst = 1'b0;

    // Round-robin fairness with all requests held
    @(negedge clk);
    #1;
    ack_cyc_q.delete();
    for (int k = 0; k < 8; k++)
      push_exp(k % N, model_f(op_a[k % N], op_b[k % N]), 1'b0, 0, 0);
    target = ack_cnt + 8;
    req = 4'b1111;
    wait_acks(target, 120);
    req = '0;
    for (int k = 1; k < ack_cyc_q.size(); k++)
      chk("rr_spacing", ack_cyc_q[k] - ack_cyc_q[k-1], 8);

    // Pointer wrap: after requester 3, 1001 gives 0 then 3
    run_op(4'b1001, 0, model_f(op_a[0], op_b[0]), 1'b0, 7, 0);
    run_op(4'b1001, 3, model_f(op_a[3], op_b[3]), 1'b0, 7, 0);
    @(negedge clk);
    chk("ptr_wrap", {30'h0, ptr_dbg}, 32'h0);

    // Stale done held through IDLE/CLEAR/ISSUE
    #1 stale_arm = 1'b1;
    run_op(4'b0010, 1, 32'h1D3B_5977, 1'b0, 7, 0);
    stale_arm = 1'b0;

    // Watchdog: done never arrives
    unit_en = 1'b0;
    run_op(4'b0100, 2, 32'h0, 1'b1, 3 + TMO, TMO);
    @(negedge clk);
    chk("wd_idle_busy", {31'h0, busy}, 32'h0);
    chk("wd_idle_state", {29'h0, state_dbg}, 32'h0);
    chk("ptr_after_wd", {30'h0, ptr_dbg}, 32'h3);

    // Reset in WAIT aborts the operation
    #1 req = 4'b0100;
    repeat (6) @(negedge clk);
    chk("mid_in_wait", {29'h0, state_dbg}, 32'h3);
    #1;
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_ptr", {30'h0, ptr_dbg}, 32'h0);
    chk("mid_ack", {28'h0, ack}, 32'h0);
    #1;
    rst = 1'b0;
    unit_en = 1'b1;
    repeat (TMO + 4) @(negedge clk);
    run_op(4'b0100, 2, model_f(op_a[2], op_b[2]), 1'b0, 7, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
